// File: rtl/muldiv_ctrl.sv
// Multiply/divide unit controller with HI/LO result registers.
// Multiply is a fixed-occupancy operation (MUL_CYCLES cycles). Divide is a
// 32-step radix-2 restoring divider on operand magnitudes, followed by one
// sign-fixup cycle. mthi/mtlo writes share the HI/LO registers. A result
// commit has priority over a same-edge mthi/mtlo write.

module muldiv_ctrl #(
    parameter int unsigned MUL_CYCLES = 2   // legal range 1..8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_div,
    input  logic        is_signed,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_SIGN
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;        // mul operand A, or dividend/quotient shift register
    logic [31:0] b_q, b_d;        // mul operand B, or divisor magnitude
    logic [31:0] rem_q, rem_d;    // partial remainder
    logic        signed_q, signed_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        commit;

    logic        accept;
    logic [31:0] abs_a, abs_b;
    logic [63:0] mul_a_ext, mul_b_ext, product;
    logic [32:0] rem_shift, rem_sub;
    logic        rem_ge;

    // A new operation is taken only from a quiet IDLE (no result pulse, no flush).
    assign accept = start & ~done_q & ~cancel & (state_q == S_IDLE);

    // Magnitudes for the divider; -0x80000000 wraps to 0x80000000, which is the
    // correct unsigned magnitude.
    assign abs_a = (is_signed & src_a[31]) ? -src_a : src_a;
    assign abs_b = (is_signed & src_b[31]) ? -src_b : src_b;

    // The low 64 bits of the product of sign- or zero-extended operands give the
    // two's-complement (or unsigned) 64-bit result.
    assign mul_a_ext = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign mul_b_ext = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product   = mul_a_ext * mul_b_ext;

    // One restoring-division step: shift in the next dividend bit, try subtract.
    assign rem_shift = {rem_q, a_q[31]};
    assign rem_ge    = (rem_shift >= {1'b0, b_q});
    assign rem_sub   = rem_shift - {1'b0, b_q};

    assign busy = (state_q != S_IDLE) | (start & ~done_q);
    assign done = done_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        signed_d  = signed_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_div) begin
                        a_d      = src_a;
                        b_d      = src_b;
                        signed_d = is_signed;
                        cnt_d    = 6'(MUL_CYCLES);
                        state_d  = S_MUL;
                    end else if (src_b == 32'd0) begin
                        // Divide by zero: no state change, HI/LO untouched.
                        done_d = 1'b1;
                    end else begin
                        a_d       = abs_a;
                        b_d       = abs_b;
                        rem_d     = 32'd0;
                        neg_quo_d = is_signed & (src_a[31] ^ src_b[31]);
                        neg_rem_d = is_signed & src_a[31];
                        cnt_d     = 6'd32;
                        state_d   = S_DIV;
                    end
                end
            end

            S_MUL: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    {hi_d, lo_d} = product;
                    commit       = 1'b1;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            S_DIV: begin
                a_d   = {a_q[30:0], rem_ge};
                rem_d = rem_ge ? rem_sub[31:0] : rem_shift[31:0];
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_SIGN;
                end
            end

            S_SIGN: begin
                lo_d    = neg_quo_q ? -a_q : a_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush: abandon everything in flight, including a commit due this edge.
        if (cancel) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            commit  = 1'b0;
        end

        // mthi/mtlo only land when no result is being written this edge.
        if (!commit) begin
            if (wr_hi) begin
                hi_d = wdata;
            end
            if (wr_lo) begin
                lo_d = wdata;
            end
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem_q     <= 32'd0;
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            signed_q  <= signed_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: table of operations with expected HI/LO and
// done latency, a scoreboard checking every done pulse, plus hand-written
// sequences for mthi/mtlo, write/commit collision, cancel and reset.

module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_div;
    logic        is_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb[$];

    typedef struct {
        logic        is_div;
        logic        is_signed;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    muldiv_ctrl #(.MUL_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .cancel    (cancel),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_div    = d;
        is_signed = s;
        src_a     = a;
        src_b     = b;
    endtask

    // Issue one operation, hold start while stalled and through the done cycle,
    // then check latency, busy profile and that no restart follows.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int lat_seen;
        int busy_bad;
        bit got;
        cyc      = 0;
        lat_seen = -1;
        busy_bad = 0;
        got      = 1'b0;
        set_op(v.is_div, v.is_signed, v.a, v.b);
        sb.push_back({v.hi, v.lo});
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (done) begin
                got      = 1'b1;
                lat_seen = cyc;
                check($sformatf("v%0d_busy_in_done_cycle", idx), 64'(busy), 64'd0);
            end else if (!busy) begin
                busy_bad++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check($sformatf("v%0d_latency", idx), 64'(lat_seen), 64'(v.lat));
        check($sformatf("v%0d_busy_while_running", idx), 64'(busy_bad), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_no_restart", idx), 64'({busy, done}), 64'd0);
        step();
    endtask

    // Scoreboard: every done pulse must match the oldest expected result.
    initial begin
        logic [63:0] exp_v;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_v = sb.pop_front();
                    check("result_hilo", {hi_o, lo_o}, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;

        // {is_div, is_signed, a, b, hi, lo, done cycle}
        vecs[0]  = '{1'b1, 1'b0, 32'd100,       32'd0,         32'h0000_0011, 32'h0000_0022, 1};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 3};
        vecs[2]  = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 3};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[4]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 34};
        vecs[5]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
        vecs[6]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3};
        vecs[7]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
        vecs[8]  = '{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 34};
        vecs[10] = '{1'b1, 1'b0, 32'd5,         32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 34};

        rst       = 1'b1;
        start     = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        cancel    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        wdata     = 32'd0;

        // Reset state, and busy during reset following start only.
        @(negedge clk);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy_idle", 64'(busy), 64'd0);
        start = 1'b1;
        #1;
        check("rst_busy_with_start", 64'(busy), 64'd1);
        start = 1'b0;
        #1;
        check("rst_busy_after_start", 64'(busy), 64'd0);
        step();
        rst = 1'b0;
        step();

        // mthi: visible next cycle only, LO untouched.
        wr_hi = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        check("mthi_no_bypass", 64'(hi_o), 64'd0);
        step();
        wr_hi = 1'b0;
        @(negedge clk);
        check("mthi_hi", 64'(hi_o), 64'h1234_5678);
        check("mthi_lo_unchanged", 64'(lo_o), 64'd0);
        step();

        // Both write enables in one cycle write the same data.
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hA5A5_A5A5;
        step();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        @(negedge clk);
        check("mthilo_both", {hi_o, lo_o}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        step();

        // Preload HI=0x11, LO=0x22 for the divide-by-zero row.
        wr_hi = 1'b1;
        wdata = 32'h11;
        step();
        wr_hi = 1'b0;
        wr_lo = 1'b1;
        wdata = 32'h22;
        step();
        wr_lo = 1'b0;
        @(negedge clk);
        check("preload_hilo", {hi_o, lo_o}, {32'h11, 32'h22});
        step();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Result commit beats a coincident mthi/mtlo write.
        set_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5);
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFB});
        step();
        step();
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hDEAD_BEEF;
        step();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        @(negedge clk);
        check("collide_done", 64'(done), 64'd1);
        step();
        start = 1'b0;

        // Cancel in cycle 10 of a divide.
        set_op(1'b1, 1'b0, 32'd100, 32'd7);
        for (int c = 0; c < 10; c++) begin
            step();
        end
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_cycle_busy", 64'(busy), 64'd1);
        step();
        cancel = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check("cancel_idle_next", 64'({busy, done}), 64'd0);
        step();
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
            step();
        end
        check("cancel_no_done", 64'(n_done), 64'd0);
        check("cancel_hilo_kept", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFB});

        // Reset asserted mid-divide.
        set_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        for (int c = 0; c < 10; c++) begin
            step();
        end
        rst = 1'b1;
        #1;
        check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_busy_start", 64'(busy), 64'd1);
        start = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        step();
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
            step();
        end
        check("rst_mid_no_done", 64'(n_done), 64'd0);
        check("rst_mid_hilo_after", {hi_o, lo_o}, 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
